// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Run-control and program store for the 4-bit CPU core.
//
// Owns the 16x8 program RAM that feeds the core's instruction fetch, fills it
// from a byte-wide loader stream, and paces core execution through a one-cycle
// clock-enable: free-run at a programmable period, single-step while halted,
// and halt on an instruction-address breakpoint.
//
// Ports
//   clk          system clock
//   n_reset      synchronous, active-low reset
//   load_start   one-cycle pulse: enter LOAD (also restarts an ongoing load)
//   load_valid   loader byte valid
//   load_data    loader byte (instruction)
//   load_ready   registered: a loader byte is accepted this cycle
//   load_done    registered one-cycle pulse after the 16th byte is written
//   run          level: 1 = free-run, 0 = halt
//   step         one-cycle pulse: execute one instruction while halted
//   div          run period minus 1, in clk cycles
//   bp_en        breakpoint enable
//   bp_addr      breakpoint instruction address
//   cpu_addr     fetch address from the CPU core
//   cpu_data     combinational: ram[cpu_addr]
//   cpu_ce       registered CPU register-update enable (single-cycle pulses)
//   cpu_n_reset  registered CPU reset, active-low (held low during LOAD)
//   bp_hit       registered, sticky: last halt was caused by the breakpoint
//   state        registered: 0 = IDLE, 1 = RUN, 2 = LOAD
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    output logic             load_ready,
    output logic             load_done,
    input  logic             run,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    input  logic             bp_en,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       cpu_addr,
    output logic [7:0]       cpu_data,
    output logic             cpu_ce,
    output logic             cpu_n_reset,
    output logic             bp_hit,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,       state_d;
    logic [DIV_W-1:0] cnt_q,         cnt_d;        // cycles left until next slot
    logic [3:0]       wptr_q,        wptr_d;       // next RAM word to load
    logic             exempt_q,      exempt_d;     // first slot after RUN entry
    logic             cpu_ce_q,      cpu_ce_d;
    logic             cpu_n_reset_q, cpu_n_reset_d;
    logic             load_ready_q,  load_ready_d;
    logic             load_done_q,   load_done_d;
    logic             bp_hit_q,      bp_hit_d;

    logic [7:0]       ram_q [16];
    logic             ram_we;

    logic             slot;       // enable slot reached this cycle
    logic             bp_match;   // breakpoint armed and fetch address matches
    logic             byte_take;  // loader handshake completes this cycle

    assign slot      = (cnt_q == '0);
    assign bp_match  = bp_en && (cpu_addr == bp_addr) && !exempt_q;
    assign byte_take = load_valid && load_ready_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets its hold/idle value first, so no branch can
        // leave a signal unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wptr_d      = wptr_q;
        exempt_d    = exempt_q;
        bp_hit_d    = bp_hit_q;
        cpu_ce_d    = 1'b0;
        load_done_d = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // load_start beats a run transition, which beats step.
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wptr_d   = '0;
                    bp_hit_d = 1'b0;
                end else if (run) begin
                    state_d  = ST_RUN;
                    cnt_d    = div;
                    exempt_d = 1'b1;
                    bp_hit_d = 1'b0;
                end else if (step) begin
                    // Single step never consults the breakpoint.
                    cpu_ce_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (load_start) begin
                    state_d  = ST_LOAD;
                    wptr_d   = '0;
                    bp_hit_d = 1'b0;
                end else if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (slot) begin
                    // div is resampled at every reload so a rate change takes
                    // effect from the next period without leaving RUN.
                    cnt_d = div;
                    if (bp_match) begin
                        // Halt before the instruction at bp_addr executes.
                        bp_hit_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        // Exempting the first slot lets a resume from the
                        // breakpoint address step past it.
                        cpu_ce_d = 1'b1;
                        exempt_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            ST_LOAD: begin
                // run and step are ignored while loading.
                if (load_start) begin
                    wptr_d = '0;
                end else if (byte_take) begin
                    ram_we = 1'b1;
                    wptr_d = wptr_q + 4'd1;
                    if (wptr_q == 4'd15) begin
                        load_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The core is held in reset and the loader is open for exactly the
        // cycles spent in LOAD; deriving both from state_d keeps them aligned
        // with the registered state.
        cpu_n_reset_d = (state_d != ST_LOAD);
        load_ready_d  = (state_d == ST_LOAD);
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wptr_q        <= '0;
            exempt_q      <= 1'b0;
            cpu_ce_q      <= 1'b0;
            cpu_n_reset_q <= 1'b0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            bp_hit_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wptr_q        <= wptr_d;
            exempt_q      <= exempt_d;
            cpu_ce_q      <= cpu_ce_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            bp_hit_q      <= bp_hit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Program RAM
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch on purpose: the program must survive
    // a reset, and a resettable array would also block RAM inference.
    always_ff @(posedge clk) begin
        if (n_reset && ram_we) begin
            ram_q[wptr_q] <= load_data;
        end
    end

    // Asynchronous read keeps the fetch path single-cycle for the core.
    assign cpu_data = ram_q[cpu_addr];

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state       = state_q;
    assign cpu_ce      = cpu_ce_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prog_sequencer
//
// Directed bench for prog_sequencer. A behavioural model of the run-control
// rules tracks the expected registered outputs and program contents; one
// process compares the DUT with it after every rising edge. Directed sequences
// add hand-computed expectations for load timing, run rate, breakpoint,
// stepping and abort behaviour. Inputs change on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_sequencer;

    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             load_start;
    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_ready;
    logic             load_done;
    logic             run;
    logic             step;
    logic [DIV_W-1:0] div;
    logic             bp_en;
    logic [3:0]       bp_addr;
    logic [3:0]       cpu_addr;
    logic [7:0]       cpu_data;
    logic             cpu_ce;
    logic             cpu_n_reset;
    logic             bp_hit;
    logic [1:0]       state;

    always #5 clk = ~clk;

    prog_sequencer #(.DIV_W(DIV_W)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .run         (run),
        .step        (step),
        .div         (div),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ce      (cpu_ce),
        .cpu_n_reset (cpu_n_reset),
        .bp_hit      (bp_hit),
        .state       (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    localparam int M_IDLE = 0, M_RUN = 1, M_LOAD = 2;

    int         m_state   = M_IDLE;
    bit         m_ce      = 0;
    bit         m_nrst    = 0;
    bit         m_ready   = 0;
    bit         m_done    = 0;
    bit         m_bp      = 0;
    bit         m_first   = 0;   // next slot is the first one since RUN entry
    int         m_written = 0;   // bytes accepted in the current load
    int         m_elapsed = 0;   // cycles since the last slot (or RUN entry)
    int         m_period  = 1;   // cycles between slots
    logic [7:0] m_mem   [16];
    bit         m_known [16];
    bit         started   = 0;

    task automatic model_update();
        int nxt;
        if (!n_reset) begin
            m_state = M_IDLE; m_ce = 0; m_nrst = 0; m_ready = 0;
            m_done = 0; m_bp = 0; m_written = 0;
            started = 1;
            return;
        end
        m_ce   = 0;
        m_done = 0;
        nxt    = m_state;
        if (m_state == M_LOAD) begin
            if (load_start) begin
                m_written = 0;
            end else if (load_valid) begin
                m_mem[m_written]   = load_data;
                m_known[m_written] = 1;
                m_written++;
                if (m_written == 16) begin
                    m_done    = 1;
                    nxt       = M_IDLE;
                    m_written = 0;
                end
            end
        end else if (load_start) begin
            nxt = M_LOAD; m_written = 0; m_bp = 0;
        end else if (m_state == M_IDLE) begin
            if (run) begin
                nxt = M_RUN; m_bp = 0; m_first = 1;
                m_elapsed = 0; m_period = int'(div) + 1;
            end else if (step) begin
                m_ce = 1;
            end
        end else begin
            if (!run) begin
                nxt = M_IDLE;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_period) begin
                    m_elapsed = 0;
                    m_period  = int'(div) + 1;
                    if (bp_en && cpu_addr == bp_addr && !m_first) begin
                        m_bp = 1; nxt = M_IDLE;
                    end else begin
                        m_ce = 1; m_first = 0;
                    end
                end
            end
        end
        m_state = nxt;
        m_nrst  = (nxt != M_LOAD);
        m_ready = (nxt == M_LOAD);
    endtask

    always @(posedge clk) begin
        model_update();
        #2;
        if (started) begin
            check("state",       32'(state),       32'(m_state));
            check("cpu_ce",      32'(cpu_ce),      32'(m_ce));
            check("cpu_n_reset", 32'(cpu_n_reset), 32'(m_nrst));
            check("load_ready",  32'(load_ready),  32'(m_ready));
            check("load_done",   32'(load_done),   32'(m_done));
            check("bp_hit",      32'(bp_hit),      32'(m_bp));
            if (m_known[cpu_addr]) check("cpu_data", 32'(cpu_data), 32'(m_mem[cpu_addr]));
        end
    end

    // -------------------------------------------------------------------------
    // CPU program counter stand-in: advances once per cpu_ce pulse
    // -------------------------------------------------------------------------
    bit follow  = 0;
    bit ce_seen = 0;

    always @(negedge clk) begin
        if (follow) begin
            if (ce_seen) cpu_addr = cpu_addr + 4'd1;
            ce_seen = cpu_ce;
        end else begin
            ce_seen = 0;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [7:0] prog [16] = '{8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    // Enter LOAD, optionally push junk bytes and restart, then write 16 bytes
    // (prog ^ mask), optionally with an idle cycle between bytes.
    task automatic load_program(input logic [7:0] mask, input bit gaps, input int junk);
        @(negedge clk); load_start = 1;
        @(negedge clk); load_start = 0;
        check("load_entry_ready", 32'(load_ready), 32'd1);
        check("load_entry_state", 32'(state), 32'd2);
        check("load_entry_nrst",  32'(cpu_n_reset), 32'd0);
        if (junk > 0) begin
            for (int j = 0; j < junk; j++) begin
                load_valid = 1; load_data = 8'hEE;
                @(negedge clk);
            end
            load_valid = 0; load_start = 1;
            @(negedge clk); load_start = 0;
            check("restart_state", 32'(state), 32'd2);
        end
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                load_valid = 0;
                @(negedge clk);
            end
            check("nrst_low_in_load", 32'(cpu_n_reset), 32'd0);
            load_valid = 1; load_data = prog[i] ^ mask;
            @(negedge clk);
        end
        load_valid = 0;
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("load_done_state", 32'(state), 32'd0);
        check("load_done_nrst",  32'(cpu_n_reset), 32'd1);
        check("load_done_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        check("load_done_single", 32'(load_done), 32'd0);
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk); cpu_addr = a;
        #1 check(name, 32'(cpu_data), 32'(exp));
    endtask

    int  cnt;
    int  first_idx;
    bit  found;

    initial begin
        n_reset = 0; load_start = 0; load_valid = 0; load_data = '0;
        run = 0; step = 0; div = '0; bp_en = 0; bp_addr = '0; cpu_addr = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state",  32'(state), 32'd0);
        check("rst_ce",     32'(cpu_ce), 32'd0);
        check("rst_nrst",   32'(cpu_n_reset), 32'd0);
        check("rst_ready",  32'(load_ready), 32'd0);
        check("rst_done",   32'(load_done), 32'd0);
        check("rst_bp",     32'(bp_hit), 32'd0);
        n_reset = 1;
        @(negedge clk);
        check("rst_release_nrst", 32'(cpu_n_reset), 32'd1);

        // Back-to-back load, then read back
        load_program(8'h00, 0, 0);
        read_check(4'd0,  8'h31, "ram0_after_load");
        read_check(4'd15, 8'h0F, "ram15_after_load");
        for (int a = 0; a < 16; a++) begin
            @(negedge clk); cpu_addr = 4'(a);
        end

        // Gapped load preceded by a restart inside LOAD
        load_program(8'hA5, 1, 3);
        read_check(4'd0, 8'h94, "ram0_after_gap_load");
        read_check(4'd3, 8'hA6, "ram3_after_gap_load");
        for (int a = 0; a < 16; a++) begin
            @(negedge clk); cpu_addr = 4'(a);
        end

        // Run rate div = 3, with a step pulse that must have no effect
        div = 24'd3;
        @(negedge clk); run = 1;
        cnt = 0; first_idx = 0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (cpu_ce) begin
                cnt++;
                if (first_idx == 0) first_idx = j;
            end
            if (j == 7) step = 1;
            if (j == 8) step = 0;
        end
        check("div3_first_pulse", 32'(first_idx), 32'd5);
        check("div3_pulse_count", 32'(cnt), 32'd3);
        run = 0;
        repeat (2) @(negedge clk);
        check("halt_state", 32'(state), 32'd0);

        // Run rate div = 0: continuous enable
        div = 24'd0;
        @(negedge clk); run = 1;
        cnt = 0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (cpu_ce) cnt++;
        end
        check("div0_pulse_count", 32'(cnt), 32'd8);
        run = 0;
        repeat (2) @(negedge clk);

        // Breakpoint at 5 with a counting program
        div = 24'd1; cpu_addr = 4'd0; bp_en = 1; bp_addr = 4'd5;
        @(negedge clk); follow = 1; run = 1;
        cnt = 0; found = 0;
        for (int j = 0; j < 100 && !found; j++) begin
            @(negedge clk);
            if (cpu_ce) cnt++;
            if (bp_hit) begin
                found = 1;
                run = 0;
            end
        end
        check("bp_reached", 32'(found), 32'd1);
        check("bp_pulses", 32'(cnt), 32'd5);
        check("bp_addr_held", 32'(cpu_addr), 32'd5);
        check("bp_state", 32'(state), 32'd0);
        @(negedge clk);
        check("bp_sticky", 32'(bp_hit), 32'd1);
        run = 1;
        @(negedge clk);
        check("bp_clear_on_run", 32'(bp_hit), 32'd0);
        repeat (9) @(negedge clk);
        check("bp_resume_no_rehit", 32'(bp_hit), 32'd0);
        check("bp_resume_advanced", 32'(cpu_addr > 4'd5), 32'd1);
        run = 0;
        repeat (2) @(negedge clk);
        follow = 0;

        // Three single steps while halted; breakpoint at cpu_addr is ignored
        cpu_addr = 4'd5; bp_addr = 4'd5; bp_en = 1;
        @(negedge clk);
        cnt = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); step = 1;
            @(negedge clk); step = 0; if (cpu_ce) cnt++;
            @(negedge clk); if (cpu_ce) cnt++;
        end
        check("step_pulses", 32'(cnt), 32'd3);
        check("step_state", 32'(state), 32'd0);
        check("step_no_bp", 32'(bp_hit), 32'd0);
        bp_en = 0;

        // Abort RUN with load_start and step on a slot cycle
        div = 24'd3;
        @(negedge clk); run = 1;
        repeat (8) @(negedge clk);
        load_start = 1; step = 1; run = 0;
        @(negedge clk); load_start = 0; step = 0;
        check("abort_state", 32'(state), 32'd2);
        check("abort_no_ce", 32'(cpu_ce), 32'd0);
        for (int i = 0; i < 5; i++) begin
            load_valid = 1; load_data = 8'h70 + 8'(i);
            @(negedge clk);
            check("abort_no_ce_load", 32'(cpu_ce), 32'd0);
        end
        load_valid = 0; n_reset = 0;
        @(negedge clk);
        check("midload_rst_state", 32'(state), 32'd0);
        check("midload_rst_nrst",  32'(cpu_n_reset), 32'd0);
        n_reset = 1;
        @(negedge clk);
        check("midload_release_nrst", 32'(cpu_n_reset), 32'd1);
        read_check(4'd0, 8'h70, "partial_ram0");
        read_check(4'd4, 8'h74, "partial_ram4");
        read_check(4'd5, 8'hA0, "partial_ram5_kept");

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run-control and program-store block for the 4-bit CPU core. Owns the 16×8 program RAM that feeds the core's instruction fetch, loads it from a byte stream, and sequences core execution through a clock-enable (free-run at a programmable rate, single-step, address breakpoint). Sits between the board I/O (buttons, loader) and the CPU core on the mother board.

## Interface
- DIV_W, 24, width of the run-rate divider
- clk  in  1  system clock
- n_reset  in  1  reset, synchronous, active-low; clock clk
- load_start  in  1  one-cycle pulse: enter LOAD
- load_valid  in  1  loader byte valid
- load_data  in  8  loader byte (instruction)
- load_ready  out  1  block accepts a loader byte this cycle
- load_done  out  1  one-cycle pulse after the 16th byte is written
- run  in  1  level: 1 = free-run, 0 = halt
- step  in  1  one-cycle pulse: execute one instruction while halted
- div  in  DIV_W  run period minus 1, in clk cycles
- bp_en  in  1  breakpoint enable
- bp_addr  in  4  breakpoint instruction address
- cpu_addr  in  4  fetch address from CPU core
- cpu_data  out  8  instruction to CPU core
- cpu_ce  out  1  CPU register-update enable (one-cycle pulses)
- cpu_n_reset  out  1  CPU reset, active-low; overrides cpu_ce in the core
- bp_hit  out  1  sticky: halted by breakpoint
- state  out  2  0 = IDLE, 1 = RUN, 2 = LOAD

## Operation
- States IDLE, RUN, LOAD; encoded on state.
- Program RAM: 16×8, asynchronous read, cpu_data = ram[cpu_addr] in every state. Not cleared by reset.
- IDLE: cpu_ce = 0 except step. step → cpu_ce = 1 for exactly one cycle; stay IDLE; step ignores breakpoint. run = 1 → RUN, clear bp_hit, load counter with div, set exempt flag.
- RUN: counter decrements each cycle; at 0 it reloads from div (sampled at reload) and an enable slot occurs. Enable slot: if bp_en and cpu_addr == bp_addr and exempt flag clear → no pulse, bp_hit = 1, → IDLE. Otherwise cpu_ce = 1, clear exempt flag. run = 0 → IDLE, counter cleared, no pulse that cycle.
- Exempt flag: first enable slot after entering RUN skips the breakpoint check, so resuming from a breakpoint address advances.
- LOAD: cpu_n_reset = 0, cpu_ce = 0, load_ready = 1. Write pointer cleared on entry. Each cycle with load_valid & load_ready: ram[wptr] ← load_data, wptr + 1. Write at wptr = 15 → load_done pulse next cycle, → IDLE, cpu_n_reset = 1 next cycle. run, step ignored in LOAD.
- load_start accepted in IDLE and RUN (aborts run, no further cpu_ce). load_start in LOAD restarts the pointer at 0.
- Priority same cycle: load_start > run transition > step.
- bp_hit cleared only by RUN entry, LOAD entry or reset.

## Timing
- All outputs registered except cpu_data (combinational from cpu_addr).
- Reset values: state IDLE, cpu_ce 0, cpu_n_reset 0 (goes 1 the first cycle after n_reset deasserts), load_ready 0, load_done 0, bp_hit 0; counter and wptr 0.
- step sampled at t → cpu_ce high at t+1 only.
- run rising sampled at t → RUN at t+1; first cpu_ce at t+2+div. Subsequent pulses every div+1 cycles; div = 0 → cpu_ce every cycle in RUN.
- Breakpoint decided on the slot cycle using current cpu_addr; bp_hit and state = IDLE visible the next cycle.
- load_start at t → state LOAD, load_ready = 1, cpu_n_reset = 0 at t+1. Max throughput one byte per cycle; 16 bytes minimum 16 cycles.
- n_reset low mid-LOAD: partial program kept, state IDLE, pointer discarded.

## Test plan
- Load: load_start, 16 back-to-back bytes 0x31,0x01,…; → load_done one cycle after 16th, ram[0] = 0x31 via cpu_addr = 0, cpu_n_reset low throughout LOAD, rises next cycle.
- Load with gaps: load_valid toggling every other cycle → exactly 16 writes, wptr unaffected by idle cycles.
- Run rate: div = 3, run = 1 → cpu_ce pulses every 4 cycles, first at 5 cycles after run sampled; div = 0 → continuous.
- Breakpoint: bp_en = 1, bp_addr = 5, program counting up → halts with cpu_addr = 5, bp_hit = 1, no pulse at slot; run re-asserted → advances past 5 without re-hit.
- Step: halted, three step pulses → exactly three single-cycle cpu_ce; step while run = 1 has no extra effect.
- Abort/priority: load_start and step same cycle in RUN → LOAD, no cpu_ce; n_reset mid-LOAD → IDLE, cpu_n_reset 0 then 1.
